// File: rtl/snax_gemmx_pkg.sv
// Shared types and parameter helpers for the GemmX D32 result narrower.
// Provides the FSM state enum plus ratio / beat-index width helpers.
package snax_gemmx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } narrow_state_e;

  function automatic int unsigned narrow_ratio(
    input int unsigned w_in,
    input int unsigned w_out
  );
    return w_in / w_out;
  endfunction

  function automatic int unsigned beat_width(
    input int unsigned ratio
  );
    return $clog2(ratio);
  endfunction

  function automatic bit narrow_params_ok(
    input int unsigned w_in,
    input int unsigned w_out
  );
    if (w_out == 0) return 1'b0;
    if ((w_in % w_out) != 0) return 1'b0;
    return (w_in / w_out) >= 2;
  endfunction

endpackage

// File: rtl/snax_gemmx_d32_narrower.sv
// Serializes one wide D32 result word into Ratio narrow beats, low first.
// Ports: acc_* wide input handshake, stream_* narrow output handshake,
//   cnt_clear_i / word_cnt_o completed-word counter, busy_o word held.
module snax_gemmx_d32_narrower
  import snax_gemmx_pkg::*;
#(
  parameter int unsigned DataWidthIn  = 2048,
  parameter int unsigned DataWidthOut = 512,
  parameter int unsigned CntWidth     = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DataWidthIn-1:0]  acc_data_i,
  input  logic                    acc_valid_i,
  output logic                    acc_ready_o,
  output logic [DataWidthOut-1:0] stream_data_o,
  output logic                    stream_valid_o,
  input  logic                    stream_ready_i,
  input  logic                    cnt_clear_i,
  output logic [CntWidth-1:0]     word_cnt_o,
  output logic                    busy_o
);

  localparam int unsigned Ratio =
    narrow_ratio(DataWidthIn, DataWidthOut);
  localparam int unsigned BeatW = beat_width(Ratio);

  if (!narrow_params_ok(DataWidthIn, DataWidthOut)) begin : g_param_err
    $error("DataWidthIn must be a multiple >= 2 of DataWidthOut");
  end

  typedef logic [BeatW-1:0] beat_t;
  typedef logic [Ratio-1:0][DataWidthOut-1:0] word_t;

  narrow_state_e state_q, state_d;
  beat_t         beat_q, beat_d;
  word_t         data_q, data_d;
  logic [CntWidth-1:0] cnt_q;

  logic last;
  logic word_done;

  assign last = (beat_q == beat_t'(Ratio - 1));

  // Last beat leaving this cycle completes the held word.
  assign word_done = (state_q == SEND) & stream_ready_i & last;

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    data_d         = data_q;
    acc_ready_o    = 1'b0;
    stream_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        acc_ready_o = 1'b1;
        if (acc_valid_i) begin
          data_d  = acc_data_i;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        stream_valid_o = 1'b1;
        // Refill only as the final beat leaves, so no bubble between words.
        acc_ready_o    = last & stream_ready_i;
        if (stream_ready_i) begin
          if (!last) begin
            beat_d = beat_q + beat_t'(1);
          end else if (acc_valid_i) begin
            data_d = acc_data_i;
            beat_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
    end
  end

  // Clear wins over a coincident completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_clear_i) begin
      cnt_q <= '0;
    end else if (word_done) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end
  end

  assign stream_data_o = data_q[beat_q];
  assign word_cnt_o    = cnt_q;
  assign busy_o        = (state_q == SEND);

endmodule

// File: tb/tb_snax_gemmx_d32_narrower.sv
// Directed bench for snax_gemmx_d32_narrower: per-cycle vector table
// plus a long back-to-back run that wraps a narrow word counter.
module tb_snax_gemmx_d32_narrower;

  localparam int WI = 2048;
  localparam int WO = 512;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [WI-1:0] acc_data;
  logic          acc_valid;
  logic          acc_ready;
  logic [WO-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          clr;
  logic [CW-1:0] cnt;
  logic          busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  snax_gemmx_d32_narrower #(
    .DataWidthIn (WI),
    .DataWidthOut(WO),
    .CntWidth    (CW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .acc_data_i    (acc_data),
    .acc_valid_i   (acc_valid),
    .acc_ready_o   (acc_ready),
    .stream_data_o (s_data),
    .stream_valid_o(s_valid),
    .stream_ready_i(s_ready),
    .cnt_clear_i   (clr),
    .word_cnt_o    (cnt),
    .busy_o        (busy)
  );

  function automatic logic [WO-1:0] slice(
    input logic [7:0] id,
    input int k
  );
    logic [7:0] kb;
    kb = 8'(k);
    return {32{id, kb}};
  endfunction

  function automatic logic [WI-1:0] mkword(input logic [7:0] id);
    logic [WI-1:0] w;
    for (int k = 0; k < 4; k++) w[k*WO +: WO] = slice(id, k);
    return w;
  endfunction

  task automatic chk(
    input string name,
    input int row,
    input logic [WO-1:0] act,
    input logic [WO-1:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %0h want %0h",
                  name, row, act, exp);
  endtask

  typedef struct {
    logic       rst;
    logic       av;
    logic [7:0] aid;
    logic       sr;
    logic       clr;
    logic       ev;
    int         dm;
    logic [7:0] eid;
    int         ek;
    logic       ear;
    logic       eb;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vq[$];

  task automatic v(
    input logic r, input logic av, input logic [7:0] aid,
    input logic sr, input logic cl,
    input logic ev, input int dm, input logic [7:0] eid, input int ek,
    input logic ear, input logic eb, input logic [7:0] ec
  );
    vec_t t;
    t.rst = r; t.av = av; t.aid = aid; t.sr = sr; t.clr = cl;
    t.ev = ev; t.dm = dm; t.eid = eid; t.ek = ek;
    t.ear = ear; t.eb = eb; t.ecnt = ec;
    vq.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bubbles;
    rst = 1'b1; acc_valid = 1'b0; acc_data = '0;
    s_ready = 1'b1; clr = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    v(0,0,0,1,0, 0,2,0,0, 1,0,0);
    // single word
    v(0,1,1,1,0, 0,0,0,0, 1,0,0);
    v(0,0,0,1,0, 1,1,1,0, 0,1,0);
    v(0,0,0,1,0, 1,1,1,1, 0,1,0);
    v(0,0,0,1,0, 1,1,1,2, 0,1,0);
    v(0,0,0,1,0, 1,1,1,3, 1,1,0);
    v(0,0,0,1,0, 0,0,0,0, 1,0,1);
    // three words back-to-back
    v(0,1,2,1,0, 0,0,0,0, 1,0,1);
    v(0,1,3,1,0, 1,1,2,0, 0,1,1);
    v(0,1,3,1,0, 1,1,2,1, 0,1,1);
    v(0,1,3,1,0, 1,1,2,2, 0,1,1);
    v(0,1,3,1,0, 1,1,2,3, 1,1,1);
    v(0,1,4,1,0, 1,1,3,0, 0,1,2);
    v(0,1,4,1,0, 1,1,3,1, 0,1,2);
    v(0,1,4,1,0, 1,1,3,2, 0,1,2);
    v(0,1,4,1,0, 1,1,3,3, 1,1,2);
    v(0,0,0,1,0, 1,1,4,0, 0,1,3);
    v(0,0,0,1,0, 1,1,4,1, 0,1,3);
    v(0,0,0,1,0, 1,1,4,2, 0,1,3);
    v(0,0,0,1,0, 1,1,4,3, 1,1,3);
    // backpressure on beat 2, pending word not taken
    v(0,1,5,1,0, 0,0,0,0, 1,0,4);
    v(0,0,0,1,0, 1,1,5,0, 0,1,4);
    v(0,0,0,1,0, 1,1,5,1, 0,1,4);
    for (int i = 0; i < 5; i++) v(0,1,6,0,0, 1,1,5,2, 0,1,4);
    v(0,0,0,1,0, 1,1,5,2, 0,1,4);
    // last-beat stall with pending word
    v(0,1,6,0,0, 1,1,5,3, 0,1,4);
    v(0,1,6,0,0, 1,1,5,3, 0,1,4);
    v(0,1,6,1,0, 1,1,5,3, 1,1,4);
    v(0,0,0,1,0, 1,1,6,0, 0,1,5);
    v(0,0,0,1,0, 1,1,6,1, 0,1,5);
    v(0,0,0,1,0, 1,1,6,2, 0,1,5);
    // clear coincident with last-beat completion
    v(0,0,0,1,1, 1,1,6,3, 1,1,5);
    v(0,0,0,1,0, 0,0,0,0, 1,0,0);
    // one word, then reset during the next
    v(0,1,7,1,0, 0,0,0,0, 1,0,0);
    v(0,0,0,1,0, 1,1,7,0, 0,1,0);
    v(0,0,0,1,0, 1,1,7,1, 0,1,0);
    v(0,0,0,1,0, 1,1,7,2, 0,1,0);
    v(0,1,8,1,0, 1,1,7,3, 1,1,0);
    v(0,0,0,1,0, 1,1,8,0, 0,1,1);
    v(1,0,0,1,0, 1,1,8,1, 0,1,1);
    v(0,0,0,1,0, 0,2,0,0, 1,0,0);
    v(0,0,0,1,0, 0,2,0,0, 1,0,0);

    for (int r = 0; r < vq.size(); r++) begin
      rst       = vq[r].rst;
      acc_valid = vq[r].av;
      acc_data  = mkword(vq[r].aid);
      s_ready   = vq[r].sr;
      clr       = vq[r].clr;
      #2;
      chk("stream_valid", r, WO'(s_valid), WO'(vq[r].ev));
      chk("acc_ready", r, WO'(acc_ready), WO'(vq[r].ear));
      chk("busy", r, WO'(busy), WO'(vq[r].eb));
      chk("word_cnt", r, WO'(cnt), WO'(vq[r].ecnt));
      if (vq[r].dm == 1)
        chk("stream_data", r, s_data, slice(vq[r].eid, vq[r].ek));
      else if (vq[r].dm == 2)
        chk("stream_data_zero", r, s_data, '0);
      tick();
    end

    // long continuous run: 2^CW words wrap the counter, no bubbles
    rst = 1'b0; clr = 1'b0; s_ready = 1'b1;
    acc_valid = 1'b1; acc_data = mkword(8'h9);
    bubbles = 0;
    for (int c = 0; c <= 1024; c++) begin
      #2;
      if (c >= 1 && !s_valid) bubbles++;
      if (c == 1021)
        chk("cnt_before_wrap", c, WO'(cnt), WO'(255));
      tick();
    end
    #2;
    chk("cnt_wrap", 1025, WO'(cnt), WO'(0));
    chk("run_bubbles", 1025, WO'(bubbles), WO'(0));
    acc_valid = 1'b0;
    repeat (4) tick();
    #2;
    chk("cnt_after_run", 1029, WO'(cnt), WO'(1));
    chk("idle_after_run", 1029, WO'(busy), WO'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/snax_gemmx_d32_narrower.md
Name: snax_gemmx_d32_narrower

Overview:
- Downstream of the GemmX accelerator's 32-bit result port (D32 output, 2048 bits).
- Accepts one wide result word per handshake and serializes it into narrower beats for the writer streamer, lowest slice first.
- Can accept the next wide word on the last beat of the current one, so a continuous stream sustains one beat per cycle.
- Keeps a completed-word counter that feeds a read-only CSR.

Parameters:
- DataWidthIn, 2048, width of the accelerator D32 result word.
- DataWidthOut, 512, width of one beat toward the streamer. DataWidthIn must be an integer multiple of DataWidthOut, with ratio ≥ 2.
- CntWidth, 32, width of the completed-word counter.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- acc_data_i  in  DataWidthIn  wide result word from the accelerator.
- acc_valid_i  in  1  wide word valid.
- acc_ready_o  out  1  block can take a wide word.
- stream_data_o  out  DataWidthOut  current beat toward the streamer.
- stream_valid_o  out  1  beat valid.
- stream_ready_i  in  1  streamer accepts the beat.
- cnt_clear_i  in  1  synchronous clear of the word counter.
- word_cnt_o  out  CntWidth  number of fully emitted wide words.
- busy_o  out  1  a wide word is held, i.e. state is SEND.

Behaviour:
- Definitions:
  - Ratio = DataWidthIn / DataWidthOut.
  - Beat index beat_q has width clog2(Ratio).
  - acc_fire = acc_valid_i & acc_ready_o.
  - out_fire = stream_valid_o & stream_ready_i.
  - last = (beat_q == Ratio-1).
- State machine IDLE / SEND.
  - IDLE:
    - acc_ready_o = 1, stream_valid_o = 0.
    - On acc_fire: data_q <= acc_data_i, beat_q <= 0, go to SEND.
  - SEND:
    - stream_valid_o = 1.
    - stream_data_o = data_q[beat_q*DataWidthOut +: DataWidthOut].
    - acc_ready_o = last & stream_ready_i (pass-through refill, combinational on stream_ready_i).
    - out_fire & !last: beat_q <= beat_q + 1.
    - out_fire & last & acc_fire: data_q <= acc_data_i, beat_q <= 0, stay in SEND, word_cnt increments.
    - out_fire & last & !acc_fire: go to IDLE, word_cnt increments.
    - No out_fire: hold all state. stream_data_o and stream_valid_o must stay stable while stalled (AXI-stream rule).
- Latency:
  - First beat is valid one cycle after acc_fire.
  - A wide word occupies Ratio cycles under no backpressure.
  - Back-to-back words give zero bubble cycles.
- Flow-control rules:
  - No combinational path from acc_valid_i to stream_valid_o.
  - stream_valid_o depends only on state.
- Word counter word_cnt_o:
  - Increments by 1 on each out_fire & last and wraps modulo 2^CntWidth.
  - cnt_clear_i has priority over increment in the same cycle (result 0).
- busy_o = (state == SEND).
- Reset, and reset mid-operation:
  - rst_i forces IDLE, beat_q = 0, data_q = 0, word_cnt_o = 0.
  - Any partially emitted word is discarded; no further beats are emitted.
  - Reset outputs: acc_ready_o = 1, stream_valid_o = 0, stream_data_o = 0, busy_o = 0, word_cnt_o = 0.
- acc_data_i is sampled only on acc_fire; it is ignored otherwise.

Decomposition:
- Shared package snax_gemmx_pkg:
  - typedef for the state enum (IDLE, SEND).
  - localparam function for Ratio and beat-index width.
  - Elaboration-time assertion on the width divisibility and ratio ≥ 2 requirements.
- No sub-module. The slice mux, counter and FSM are small enough for one module.
- Optional: instantiate the existing common counter cell for word_cnt if the team prefers.

Test Plan:
1. Single word:
   - Stimulus: DataWidthIn = 2048, DataWidthOut = 512, word = {D, C, B, A} (512-bit slices), stream_ready_i = 1.
   - Response: beats A, B, C, D on cycles 1–4 after acc_fire; acc_ready_o = 0 on cycles 1–3 and 1 on cycle 4; word_cnt_o = 1; busy_o back to 0 on cycle 5.
2. Back-to-back stream:
   - Stimulus: 3 words presented continuously, stream_ready_i = 1.
   - Response: 12 consecutive valid beats with no bubble; second word accepted in the same cycle as the first word's beat 3; word_cnt_o = 3.
3. Backpressure:
   - Stimulus: stream_ready_i deasserted for 5 cycles during beat 2.
   - Response: stream_data_o holds slice 2 and stream_valid_o stays 1; acc_ready_o = 0 throughout; emission resumes with slice 2 and then slice 3.
4. Last-beat stall with a pending word:
   - Stimulus: on beat 3, acc_valid_i = 1 and stream_ready_i = 0.
   - Response: acc_ready_o = 0 and the new word is not taken; it is accepted in the cycle stream_ready_i rises.
5. Counter:
   - Stimulus: preload word_cnt to 2^32−1 via 2^32−1 words (or force), then complete one more word; separately assert cnt_clear_i in the same cycle as a last-beat out_fire.
   - Response: counter wraps to 0; clear with simultaneous increment yields 0.
6. Mid-operation reset:
   - Stimulus: assert rst_i for 1 cycle after beat 1.
   - Response: next cycle stream_valid_o = 0, busy_o = 0, word_cnt_o = 0, acc_ready_o = 1; beats 2 and 3 are never emitted.
